// File: rtl/fpu_mul_result_queue_pkg.sv
// ============================================================================
// fpu_mul_result_queue_pkg : shared FPU field constants, flags struct, helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_mul_result_queue_pkg;

  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          FRAC_MSB = 22;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic is_nan;
    logic overflow;
    logic error;
  } fpu_flags_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[EXP_MSB:EXP_LSB] == EXP_MAX) && (w[FRAC_MSB:0] != 23'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_mul_result_queue.sv
// ============================================================================
// fpu_mul_result_queue : show-ahead result FIFO with sticky flags, error count
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_mul_result_queue
  import fpu_mul_result_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_error,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sticky_error,
  output logic                     sticky_overflow,
  input  logic                     sticky_clr,
  output logic [CNT_W-1:0]         err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] result;
    fpu_flags_t  flags;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               sticky_err_q, sticky_err_d;
  logic               sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic   push;
  logic   pop;
  entry_t wr_entry;

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry.result         = in_result;
  assign wr_entry.flags.is_nan   = is_nan(in_result);
  assign wr_entry.flags.overflow = in_overflow;
  assign wr_entry.flags.error    = in_error;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    err_cnt_d    = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Set beats clear when a flagged push lands on the same edge as sticky_clr
    sticky_err_d = (sticky_err_q & ~sticky_clr) | (push & in_error);
    sticky_ovf_d = (sticky_ovf_q & ~sticky_clr) | (push & in_overflow);
    if (push && in_error && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sticky_err_q <= 1'b0;
      sticky_ovf_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sticky_err_q <= sticky_err_d;
      sticky_ovf_q <= sticky_ovf_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_result      = mem_q[rd_ptr_q].result;
  assign out_flags       = mem_q[rd_ptr_q].flags;
  assign level           = level_q;
  assign sticky_error    = sticky_err_q;
  assign sticky_overflow = sticky_ovf_q;
  assign err_count       = err_cnt_q;

endmodule

`default_nettype wire
